// File: rtl/retire.sv
// ---------------------------------------------------------------------------
// retire -- in-order retirement stage.
//
// Accepts one completed result per cycle from the execution units. A result
// whose tag matches the current instruction-stream tag is live. A live result
// can write the register bank, redirect fetch, or do both. A result with any
// other tag is stale and is dropped. Each live redirect advances the stream
// tag. The stage then spends one REDIRECT cycle, with in_ready low, while
// fetch restarts.
//
// Optional feature: define RETIRE_COUNT_EN to add the retired_cnt output.
// retired_cnt is a 32-bit wrapping count of live accepted results.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   in_valid     in   1   a completed result is presented
//   in_ready     out  1   result is accepted this cycle (high in RUN)
//   in_tag       in   4   instruction-stream tag of the result
//   in_wb        in   1   result writes a destination register
//   in_rd        in   5   destination register index
//   in_data      in  32   result value
//   in_jump      in   1   result redirects the PC
//   in_target    in  32   redirect target
//   reg_we       out  1   register-bank write strobe
//   reg_addr     out  5   register-bank write index
//   reg_data     out 32   register-bank write data
//   set_pc       out  1   one-cycle pulse: fetch loads new_pc
//   new_pc       out 32   redirect address (holds between pulses)
//   cur_tag      out  4   tag of the currently valid stream
//   retired_cnt  out 32   live results retired (RETIRE_COUNT_EN only)
//   discard_cnt  out 16   saturating count of dropped stale results
// ---------------------------------------------------------------------------
module retire #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_tag,
  input  logic        in_wb,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  input  logic        in_jump,
  input  logic [31:0] in_target,
  output logic        reg_we,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_data,
  output logic        set_pc,
  output logic [31:0] new_pc,
  output logic [3:0]  cur_tag,
`ifdef RETIRE_COUNT_EN
  output logic [31:0] retired_cnt,
`endif
  output logic [15:0] discard_cnt
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]  state_q,       state_d;
  logic [3:0]  cur_tag_q,     cur_tag_d;
  logic        reg_we_q,      reg_we_d;
  logic [4:0]  reg_addr_q,    reg_addr_d;
  logic [31:0] reg_data_q,    reg_data_d;
  logic        set_pc_q,      set_pc_d;
  logic [31:0] new_pc_q,      new_pc_d;
  logic [15:0] discard_cnt_q, discard_cnt_d;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
`endif

  logic accept;
  logic live;
  logic stale;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  // cur_tag_q is the pre-increment tag. A redirect in this same transfer
  // only takes effect at the next edge.
  assign live     = accept && (in_tag == cur_tag_q);
  assign stale    = accept && (in_tag != cur_tag_q);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cur_tag_d     = cur_tag_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_data_d    = reg_data_q;
    set_pc_d      = 1'b0;
    new_pc_d      = new_pc_q;
    discard_cnt_d = discard_cnt_q;
`ifdef RETIRE_COUNT_EN
    retired_cnt_d = retired_cnt_q;
`endif

    // x0 is hardwired to zero, so a write to it is dropped here.
    if (live && in_wb && (in_rd != 5'd0)) begin
      reg_we_d   = 1'b1;
      reg_addr_d = in_rd;
      reg_data_d = in_data;
    end

    // The write and the redirect are independent. A jump-and-link does both
    // in the same cycle.
    if (live && in_jump) begin
      set_pc_d  = 1'b1;
      new_pc_d  = {in_target[31:1], 1'b0};
      cur_tag_d = cur_tag_q + 4'd1;  // 4-bit wrap: 15 -> 0
    end

    if (stale && (discard_cnt_q != 16'hFFFF)) begin
      discard_cnt_d = discard_cnt_q + 16'd1;
    end

`ifdef RETIRE_COUNT_EN
    if (live) begin
      retired_cnt_d = retired_cnt_q + 32'd1;
    end
`endif

    case (state_q)
      ST_RUN:      if (live && in_jump) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only. All flops then
  // sample their _d values together at the edge, with no ordering races.
  // The asynchronous reset clears a pending REDIRECT, so no set_pc pulse
  // follows reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      cur_tag_q     <= 4'd0;
      reg_we_q      <= 1'b0;
      reg_addr_q    <= 5'd0;
      reg_data_q    <= 32'd0;
      set_pc_q      <= 1'b0;
      new_pc_q      <= RESET_PC;
      discard_cnt_q <= 16'd0;
`ifdef RETIRE_COUNT_EN
      retired_cnt_q <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      cur_tag_q     <= cur_tag_d;
      reg_we_q      <= reg_we_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_q    <= reg_data_d;
      set_pc_q      <= set_pc_d;
      new_pc_q      <= new_pc_d;
      discard_cnt_q <= discard_cnt_d;
`ifdef RETIRE_COUNT_EN
      retired_cnt_q <= retired_cnt_d;
`endif
    end
  end

  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign set_pc      = set_pc_q;
  assign new_pc      = new_pc_q;
  assign cur_tag     = cur_tag_q;
  assign discard_cnt = discard_cnt_q;
`ifdef RETIRE_COUNT_EN
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_retire.sv
// ---------------------------------------------------------------------------
// tb_retire -- directed testbench for retire.
//
// Inputs change 1 ns after a rising edge. Registered outputs are sampled at
// that same point, clear of the active edge. All expected values are
// written out by hand below.
// ---------------------------------------------------------------------------
module tb_retire;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_tag = 4'd0;
  logic        in_wb = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_data = 32'd0;
  logic        in_jump = 1'b0;
  logic [31:0] in_target = 32'd0;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        set_pc;
  logic [31:0] new_pc;
  logic [3:0]  cur_tag;
  logic [15:0] discard_cnt;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  retire #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tag      (in_tag),
    .in_wb       (in_wb),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .in_jump     (in_jump),
    .in_target   (in_target),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .set_pc      (set_pc),
    .new_pc      (new_pc),
    .cur_tag     (cur_tag),
`ifdef RETIRE_COUNT_EN
    .retired_cnt (retired_cnt),
`endif
    .discard_cnt (discard_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present one result for exactly one rising edge, then drop in_valid.
  task automatic drive(input logic [3:0] tag, input logic wb, input logic [4:0] rd,
                       input logic [31:0] data, input logic jump, input logic [31:0] target);
    in_tag    = tag;
    in_wb     = wb;
    in_rd     = rd;
    in_data   = data;
    in_jump   = jump;
    in_target = target;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cur_tag", 32'(cur_tag), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_data", reg_data, 32'd0);
    check("rst_set_pc", 32'(set_pc), 32'd0);
    check("rst_new_pc", new_pc, RST_PC);
    check("rst_discard", 32'(discard_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Plain write to x5
    drive(4'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd0);
    check("wr_we", 32'(reg_we), 32'd1);
    check("wr_addr", 32'(reg_addr), 32'd5);
    check("wr_data", reg_data, 32'hDEAD_BEEF);
    check("wr_set_pc", 32'(set_pc), 32'd0);
    idle();
    check("wr_we_drop", 32'(reg_we), 32'd0);

    // Write to x0 is suppressed
    drive(4'd0, 1'b1, 5'd0, 32'h1, 1'b0, 32'd0);
    check("x0_we", 32'(reg_we), 32'd0);
    idle();
    check("x0_we_after", 32'(reg_we), 32'd0);

    // Jump and link: bit 0 of the target is cleared
    drive(4'd0, 1'b1, 5'd1, 32'h104, 1'b1, 32'h0000_1001);
    check("jl_set_pc", 32'(set_pc), 32'd1);
    check("jl_new_pc", new_pc, 32'h0000_1000);
    check("jl_we", 32'(reg_we), 32'd1);
    check("jl_addr", 32'(reg_addr), 32'd1);
    check("jl_data", reg_data, 32'h104);
    check("jl_cur_tag", 32'(cur_tag), 32'd1);
    check("jl_in_ready", 32'(in_ready), 32'd0);
    idle();
    check("jl_set_pc_drop", 32'(set_pc), 32'd0);
    check("jl_ready_back", 32'(in_ready), 32'd1);
    check("jl_new_pc_hold", new_pc, 32'h0000_1000);
    check("jl_we_drop", 32'(reg_we), 32'd0);

    // Stale write is dropped, then a live write with the new tag goes through
    drive(4'd0, 1'b1, 5'd3, 32'h55, 1'b0, 32'd0);
    check("stale_we", 32'(reg_we), 32'd0);
    check("stale_discard", 32'(discard_cnt), 32'd1);
    drive(4'd1, 1'b1, 5'd3, 32'h7, 1'b0, 32'd0);
    check("live_we", 32'(reg_we), 32'd1);
    check("live_addr", 32'(reg_addr), 32'd3);
    check("live_data", reg_data, 32'h7);
    check("live_discard", 32'(discard_cnt), 32'd1);

    // Stale jump: no redirect, no tag change
    drive(4'd0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_2000);
    check("sj_set_pc", 32'(set_pc), 32'd0);
    check("sj_cur_tag", 32'(cur_tag), 32'd1);
    check("sj_in_ready", 32'(in_ready), 32'd1);
    check("sj_new_pc", new_pc, 32'h0000_1000);
    check("sj_discard", 32'(discard_cnt), 32'd2);

    // A result held valid through REDIRECT is taken only once RUN resumes
    drive(4'd1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_3000);
    check("hold_cur_tag", 32'(cur_tag), 32'd2);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    in_tag = 4'd2; in_wb = 1'b1; in_rd = 5'd7; in_data = 32'h99; in_jump = 1'b0;
    in_valid = 1'b1;
    idle();
    check("hold_ignored_we", 32'(reg_we), 32'd0);
    check("hold_ready_back", 32'(in_ready), 32'd1);
    idle();
    in_valid = 1'b0;
    check("hold_taken_we", 32'(reg_we), 32'd1);
    check("hold_taken_addr", 32'(reg_addr), 32'd7);
    check("hold_taken_data", reg_data, 32'h99);

    // Reset asserted during the REDIRECT cycle
    drive(4'd2, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_4000);
    check("rr_in_redirect", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rr_set_pc", 32'(set_pc), 32'd0);
    check("rr_cur_tag", 32'(cur_tag), 32'd0);
    check("rr_new_pc", new_pc, RST_PC);
    check("rr_in_ready", 32'(in_ready), 32'd1);
    check("rr_discard", 32'(discard_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    // First edge after release accepts tag 0, and no stale pulse appears
    drive(4'd0, 1'b1, 5'd9, 32'hA5A5_0000, 1'b0, 32'd0);
    check("rel_we", 32'(reg_we), 32'd1);
    check("rel_addr", 32'(reg_addr), 32'd9);
    check("rel_set_pc", 32'(set_pc), 32'd0);
    check("rel_in_ready", 32'(in_ready), 32'd1);
`ifdef RETIRE_COUNT_EN
    check("rel_retired", retired_cnt, 32'd1);
`endif

    // Sixteen live jumps: tag runs 1..15 and then wraps to 0
    for (int i = 0; i < 16; i++) begin
      logic [3:0] t;
      logic [3:0] tn;
      t  = 4'(i);
      tn = 4'(i + 1);
      drive(t, 1'b0, 5'd0, 32'd0, 1'b1, 32'(i * 256 + 3));
      if (set_pc === 1'b1) pulses++;
      check("wrap_cur_tag", 32'(cur_tag), 32'(tn));
      check("wrap_new_pc", new_pc, 32'(i * 256 + 2));
      check("wrap_in_ready", 32'(in_ready), 32'd0);
      idle();
      check("wrap_set_pc_drop", 32'(set_pc), 32'd0);
      check("wrap_ready_back", 32'(in_ready), 32'd1);
    end
    check("wrap_pulses", 32'(pulses), 32'd16);
    check("wrap_final_tag", 32'(cur_tag), 32'd0);
`ifdef RETIRE_COUNT_EN
    check("wrap_retired", retired_cnt, 32'd17);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
